add_one_serial: RTL and testbench
=================================

ADD_ONE_SERIAL -- requirements
Module: add1

Interface
REQ-001 SHALL have parameter NUMBITS, default 4, meaning word length in bits of each serial operand (legal range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-004 SHALL have port input_bit  input  1  serial operand bit, LSB first, one bit per clk cycle.
REQ-005 SHALL have port output_bit  output  1  serial result bit (operand + 1), LSB first, registered.
REQ-006 SHALL support positional instantiation in the order clk, reset, input_bit, output_bit.

Function
REQ-007 SHALL implement a bit-serial incrementer: for each NUMBITS-bit word fed LSB first, the output bit stream equals (word + 1) mod 2^NUMBITS, LSB first.
REQ-008 SHALL use a two-state FSM: CARRY (carry-in = 1) and NOCARRY (carry-in = 0).
REQ-009 SHALL, each rising edge with reset=1, register output_bit <= input_bit XOR carry, where carry = 1 in CARRY, 0 in NOCARRY.
REQ-010 SHALL transition CARRY -> CARRY when input_bit = 1, CARRY -> NOCARRY when input_bit = 0, NOCARRY -> NOCARRY for any input_bit.
REQ-011 SHALL have latency of exactly one clock: bit k presented before edge n appears on output_bit after edge n and holds until edge n+1.
REQ-012 SHALL keep a bit counter 0..NUMBITS-1, incremented on every non-reset rising edge.
REQ-013 SHALL, on the edge that consumes bit NUMBITS-1 (word boundary), load counter to 0 and FSM to CARRY regardless of input_bit, so back-to-back words need no reset.
REQ-014 SHALL discard the final carry-out on wrap-around (all-ones word yields all-zeros output, no overflow flag).
REQ-015 SHALL treat input_bit as sampled only at rising edges; changes between edges have no effect.
REQ-016 SHALL be fully synthesizable, no latches, no combinational path from input_bit to output_bit.

Reset
REQ-017 SHALL, while reset=0, hold FSM in CARRY, counter at 0, output_bit at 0.
REQ-018 SHALL, on reset deassertion, treat the bit presented before the next rising edge as bit 0 (LSB) of a new word.
REQ-019 SHALL, on reset asserted mid-word, abandon the partial word with no residual carry or count state.
REQ-020 SHALL ignore input_bit on any edge where reset=0.

Verification
REQ-021 SHALL pass: reset pulse, then input 0000 (LSB first 0,0,0,0) -> output stream 1,0,0,0 (0001).
REQ-022 SHALL pass: reset, input 0111 (1,1,1,0) -> output 0,0,0,1 (1000); FSM in CARRY for first three edges.
REQ-023 SHALL pass: reset, input 1111 -> output 0000 (wrap-around, carry-out dropped).
REQ-024 SHALL pass: exhaustive NUMBITS=4, each of 0..15 preceded by reset -> output equals input+1 mod 16 for all 16 values.
REQ-025 SHALL pass: back-to-back words 0011 then 0101 without reset -> outputs 0100 then 0110 (word-boundary re-arm).
REQ-026 SHALL pass: assert reset=0 after two bits of 1111, release, feed 0010 -> output 0011, and output_bit=0 immediately on reset assertion without a clock edge.

Source files
------------

// File: rtl/add_one_serial.sv
// Bit-serial incrementer: adds one to each NUMBITS-bit word streamed LSB first.
// Output is registered, so results trail the operand by exactly one clock.
module add_one_serial #(
    parameter int NUMBITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic input_bit,
    output logic output_bit
);

    localparam int CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

    typedef enum logic {
        CARRY,
        NOCARRY
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CARRY;
            count      <= '0;
            output_bit <= 1'b0;
        end else begin
            output_bit <= input_bit ^ (state == CARRY);
            // Word boundary re-arms the carry; the carry-out of the MSB is dropped.
            if (count == LAST) begin
                count <= '0;
                state <= CARRY;
            end else begin
                count <= count + CW'(1);
                if (state == CARRY && !input_bit) begin
                    state <= NOCARRY;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_one_serial.sv
// Directed bench for add_one_serial with NUMBITS=4.
// Every step leaves the bench parked at a falling clock edge.
module tb_add_one_serial;

    logic clk;
    logic reset;
    logic input_bit;
    logic output_bit;

    int compared;
    int mismatched;

    add_one_serial #(.NUMBITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .input_bit (input_bit),
        .output_bit(output_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Assert reset at a falling edge, check the asynchronous clear, clock once
    // with input high to show it is ignored, then release.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_async_clear"}, output_bit, 1'b0);
        input_bit = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_held"}, output_bit, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        input_bit = 1'b0;
    endtask

    task automatic send_bit(input string tag, input logic b, input logic exp);
        input_bit = b;
        @(posedge clk);
        #1;
        check(tag, output_bit, exp);
        @(negedge clk);
    endtask

    task automatic send_word(input string tag, input logic [3:0] w,
                             input logic [3:0] exp);
        for (int i = 0; i < 4; i++) begin
            send_bit($sformatf("%s_b%0d", tag, i), w[i], exp[i]);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        input_bit  = 1'b0;
        #1;
        check("reset_out", output_bit, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        send_word("w0000", 4'b0000, 4'b0001);

        do_reset("r1");
        send_word("w0111", 4'b0111, 4'b1000);

        do_reset("r2");
        send_word("w1111", 4'b1111, 4'b0000);

        for (int v = 0; v < 16; v++) begin
            logic [3:0] w;
            logic [3:0] e;
            w = 4'(v);
            e = 4'((v + 1) % 16);
            do_reset($sformatf("rx%0d", v));
            send_word($sformatf("x%0d", v), w, e);
        end

        do_reset("r3");
        send_word("b2b_a", 4'b0011, 4'b0100);
        send_word("b2b_b", 4'b0101, 4'b0110);
        send_word("b2b_c", 4'b1111, 4'b0000);

        // Abandon 1111 after two bits; the next word must start clean.
        do_reset("r4");
        send_bit("mid_b0", 1'b1, 1'b0);
        send_bit("mid_b1", 1'b1, 1'b0);
        do_reset("r5");
        send_word("w0010", 4'b0010, 4'b0011);

        // Reset while output is high shows the clear is immediate.
        send_bit("hi_b0", 1'b0, 1'b1);
        do_reset("r6");
        send_word("w0101", 4'b0101, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
